// File: rtl/seq_divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package divider_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned CNT_W         = $clog2(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } state_e;

  // Counter width for a given operand width; it must hold WIDTH-1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake and result bus between the ALU sequencer and the divider.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 4
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_trial_sub.sv
// Ripple add/sub cell and the subtract-mode chain used for the trial subtraction.
module fulladdsub (
  input  logic a_i,
  input  logic b_i,
  input  logic sel_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  logic b_eff;

  assign b_eff  = b_i ^ sel_i;
  assign sum_o  = a_i ^ b_eff ^ cin_i;
  assign cout_o = (a_i & b_eff) | (a_i & cin_i) | (b_eff & cin_i);

endmodule

module trial_sub #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_o
);

  logic [N:0] carry;

  // Subtract mode: invert b and inject the +1 through the LSB carry.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_stage
    fulladdsub u_cell (
      .a_i    (a_i[i]),
      .b_i    (b_i[i]),
      .sel_i  (1'b1),
      .cin_i  (carry[i]),
      .sum_o  (diff_o[i]),
      .cout_o (carry[i+1])
    );
  end

  assign borrow_o = ~carry[N];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one trial subtraction per clock.
module seq_divider
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned CW = cnt_width(WIDTH);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  q_q;
  logic [W-1:0]  d_q;
  logic [W-1:0]  r_q;
  logic          busy_q;
  logic          done_q;
  logic [W-1:0]  quot_q;
  logic [W-1:0]  rem_q;
  logic          dbz_q;

  logic [W:0]    shifted;
  logic [W:0]    diff;
  logic          borrow;
  logic [W-1:0]  q_d;
  logic [W-1:0]  r_d;

  // The partial remainder's top bit is always zero after a step, so only
  // the low WIDTH bits are stored; the extra bit lives in the shifted value.
  assign shifted = {r_q, q_q[W-1]};

  trial_sub #(
    .N (W + 1)
  ) u_trial_sub (
    .a_i      (shifted),
    .b_i      ({1'b0, d_q}),
    .diff_o   (diff),
    .borrow_o (borrow)
  );

  always_comb begin
    q_d = {q_q[W-2:0], 1'b0};
    r_d = shifted[W-1:0];
    if (!diff[W]) begin
      q_d = {q_q[W-2:0], 1'b1};
      r_d = diff[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            q_q     <= bus.dividend;
            d_q     <= bus.divisor;
            r_q     <= '0;
            cnt_q   <= CW'(W - 1);
            dbz_q   <= (bus.divisor == '0);
            busy_q  <= 1'b1;
            state_q <= DIVIDE;
          end
        end
        DIVIDE: begin
          q_q <= q_d;
          r_q <= r_d;
          if (cnt_q == '0) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          quot_q  <= q_q;
          rem_q   <= r_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Sign bit and chain borrow must agree for in-range operands.
  always_ff @(posedge clk) begin
    if (!rst && state_q == DIVIDE) begin
      assert (borrow == diff[W]);
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=4): directed vectors plus full sweep.
module tb_seq_divider;

  logic clk;
  logic rst;

  seq_divider_if #(.WIDTH(4)) bus ();

  seq_divider #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every done pops one expected result.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", bus.quotient, e.q);
        check("remainder", bus.remainder, e.r);
        check("div_by_zero", bus.div_by_zero, e.dbz);
      end
    end
  end

  task automatic wait_idle();
    int ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("wait_idle", 0, 1);
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] eq, input logic [3:0] er, input logic edbz,
                        input bit lat_chk, input bit hold, input logic [3:0] hq,
                        input logic [3:0] hr);
    int lat;
    int nbusy;
    wait_idle();
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    sb.push_back('{q: eq, r: er, dbz: edbz});
    @(posedge clk);
    #1 bus.start = 1'b0;
    if (lat_chk) begin
      lat   = 0;
      nbusy = int'(bus.busy);
      for (int i = 1; i <= 20; i++) begin
        if (hold) begin
          check("hold_quotient", bus.quotient, hq);
          check("hold_remainder", bus.remainder, hr);
        end
        @(posedge clk);
        #1;
        if (bus.done) begin
          lat = i;
          break;
        end
        nbusy += int'(bus.busy);
      end
      check("latency", lat, 5);
      check("busy_cycles", nbusy, 5);
    end
  endtask

  initial begin
    int t[3];
    int got;
    int nd;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_quotient", bus.quotient, 0);
    check("rst_remainder", bus.remainder, 0);
    check("rst_dbz", bus.div_by_zero, 0);
    rst = 1'b0;

    run_op(4'd13, 4'd3, 4'd4,  4'd1, 1'b0, 1, 0, 4'd0,  4'd0);
    run_op(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 1, 0, 4'd0,  4'd0);
    run_op(4'd2,  4'd9, 4'd0,  4'd2, 1'b0, 1, 1, 4'd15, 4'd0);
    run_op(4'd7,  4'd0, 4'd15, 4'd7, 1'b1, 1, 0, 4'd0,  4'd0);
    run_op(4'd8,  4'd2, 4'd4,  4'd0, 1'b0, 1, 0, 4'd0,  4'd0);

    // start held high: accepted only on the IDLE cycles
    wait_idle();
    bus.dividend = 4'd9;
    bus.divisor  = 4'd4;
    bus.start    = 1'b1;
    sb.push_back('{q: 4'd2, r: 4'd1, dbz: 1'b0});
    for (int k = 0; k < 3; k++) begin
      got = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.done) begin
          got = 1;
          break;
        end
      end
      check("cont_done_seen", got, 1);
      t[k] = cyc;
      check("cont_busy_at_done", bus.busy, 0);
      if (k < 2) sb.push_back('{q: 4'd2, r: 4'd1, dbz: 1'b0});
      else bus.start = 1'b0;
    end
    check("cont_spacing_1", t[1] - t[0], 6);
    check("cont_spacing_2", t[2] - t[1], 6);

    // reset during the 2nd DIVIDE cycle discards the operation
    wait_idle();
    bus.dividend = 4'd14;
    bus.divisor  = 4'd5;
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_quotient", bus.quotient, 0);
    check("midrst_remainder", bus.remainder, 0);
    rst = 1'b0;
    nd = 0;
    repeat (12) begin
      @(posedge clk);
      #1 nd += int'(bus.done);
    end
    check("no_done_after_rst", nd, 0);
    run_op(4'd14, 4'd5, 4'd2, 4'd4, 1'b0, 1, 0, 4'd0, 4'd0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0)
          run_op(4'(a), 4'(b), 4'd15, 4'(a), 1'b1, 0, 0, 4'd0, 4'd0);
        else
          run_op(4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0, 0, 0, 4'd0, 4'd0);
      end
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
